// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port sync VRAM between video scanout (fixed priority) and a one-entry cpu buffer.
// Latency: grant in cycle A, RAM address at A+1, ack/valid at A+2; uncontested cpu strobe to ack is 3 cycles.
// Backpressure: cpu_busy while the buffer holds an access; cpu forced in after STARVE_LIMIT video grants. VRAM_ARB_STATS_EN enables stall_cnt.
module vram_arbiter #(
    parameter int AW           = 12,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_busy,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_valid,
    output logic [DW-1:0] vid_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stall_cnt
);

    logic          buf_full;
    logic          buf_issued;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_wdata;
    logic [7:0]    starve_cnt;

    logic          s1_vld, s1_cpu, s1_rd;
    logic          s2_vld, s2_cpu, s2_rd;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] vid_rdata_q;

    logic          cpu_cand;
    logic          grant_cpu;
    logic          grant_vid;
    logic          ack_cpu;
    logic          accept;

    assign cpu_cand  = buf_full & ~buf_issued;
    assign grant_cpu = cpu_cand & (~vid_req | (starve_cnt == 8'(STARVE_LIMIT)));
    assign grant_vid = vid_req & ~grant_cpu;
    assign ack_cpu   = s2_vld & s2_cpu;
    // The ack cycle frees the entry, so a strobe landing in it is taken.
    assign accept    = cpu_req & (~buf_full | ack_cpu);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_full   <= 1'b0;
            buf_issued <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= '0;
        end else if (accept) begin
            buf_full   <= 1'b1;
            buf_issued <= 1'b0;
            buf_we     <= cpu_we;
            buf_addr   <= cpu_addr;
            buf_wdata  <= cpu_wdata;
        end else if (ack_cpu) begin
            buf_full   <= 1'b0;
            buf_issued <= 1'b0;
        end else if (grant_cpu) begin
            buf_issued <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= 8'd0;
        end else if (grant_cpu || !cpu_cand) begin
            starve_cnt <= 8'd0;
        end else if (grant_vid && starve_cnt < 8'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            s1_vld    <= 1'b0;
            s1_cpu    <= 1'b0;
            s1_rd     <= 1'b0;
            s2_vld    <= 1'b0;
            s2_cpu    <= 1'b0;
            s2_rd     <= 1'b0;
        end else begin
            mem_we <= grant_cpu & buf_we;
            if (grant_cpu) begin
                mem_addr  <= buf_addr;
                mem_wdata <= buf_wdata;
            end else if (grant_vid) begin
                mem_addr  <= vid_addr;
            end
            s1_vld <= grant_cpu | grant_vid;
            s1_cpu <= grant_cpu;
            s1_rd  <= ~(grant_cpu & buf_we);
            s2_vld <= s1_vld;
            s2_cpu <= s1_cpu;
            s2_rd  <= s1_rd;
        end
    end

    // Read data passes straight through in the ack/valid cycle, then is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            if (ack_cpu && s2_rd)
                cpu_rdata_q <= mem_rdata;
            if (s2_vld && !s2_cpu)
                vid_rdata_q <= mem_rdata;
        end
    end

    assign cpu_busy  = buf_full;
    assign cpu_ack   = ack_cpu;
    assign cpu_rdata = (ack_cpu && s2_rd) ? mem_rdata : cpu_rdata_q;
    assign vid_ack   = grant_vid & ~reset;
    assign vid_valid = s2_vld & ~s2_cpu;
    assign vid_rdata = (s2_vld && !s2_cpu) ? mem_rdata : vid_rdata_q;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_q <= 16'h0000;
        else if (cpu_cand && !grant_cpu && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'h0001;
    end
    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboarded bench for vram_arbiter: directed scenarios then randomized cpu/video traffic against a memory model.
module tb_vram_arbiter;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int LIM = 8;
`ifdef VRAM_ARB_STATS_EN
    localparam int EXP_STALL = 8;
`else
    localparam int EXP_STALL = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_busy, cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack, vid_valid;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata = '0;
    logic [15:0]   stall_cnt;

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_valid(vid_valid), .vid_rdata(vid_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int vid_ack_cnt = 0, vid_valid_cnt = 0, cpu_ack_cnt = 0;

    function automatic logic [7:0] pat(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    // Behavioural RAM: unwritten locations read back a fixed pattern.
    logic [7:0] ram [4096];
    bit         written [4096];
    always @(posedge clock) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : pat(mem_addr);
    end

    logic [7:0] mdl [4096];
    logic [8:0] cpu_q [$];
    logic [7:0] vid_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [8:0] ce;
    logic [7:0] ve;
    always @(negedge clock) begin
        if (!reset) begin
            if (cpu_ack) begin
                cpu_ack_cnt++;
                if (cpu_q.size() == 0) chk("spurious_cpu_ack", {31'b0, cpu_ack}, 32'd0);
                else begin
                    ce = cpu_q.pop_front();
                    if (!ce[8]) chk("cpu_rdata", {24'b0, cpu_rdata}, {24'b0, ce[7:0]});
                end
            end
            if (vid_valid) begin
                vid_valid_cnt++;
                if (vid_q.size() == 0) chk("spurious_vid_valid", {31'b0, vid_valid}, 32'd0);
                else begin
                    ve = vid_q.pop_front();
                    chk("vid_rdata", {24'b0, vid_rdata}, {24'b0, ve});
                end
            end
            if (vid_ack) begin
                vid_ack_cnt++;
                vid_q.push_back(pat(vid_addr));
            end
        end
    end

    task automatic push_cpu(input logic we, input logic [11:0] a, input logic [7:0] d);
        if (we) begin
            cpu_q.push_back({1'b1, 8'h00});
            mdl[a] = d;
        end else begin
            cpu_q.push_back({1'b0, mdl[a]});
        end
    endtask

    task automatic strobe(input logic we, input logic [11:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    // Issues one cpu access and returns the strobe-to-ack distance in cycles.
    task automatic cpu_op(input logic we, input logic [11:0] a, input logic [7:0] d, output int lat);
        step();
        strobe(we, a, d);
        push_cpu(we, a, d);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            step();
            cpu_req = 1'b0;
            @(negedge clock);
            if (cpu_ack) lat = k;
        end
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL cpu_ack_timeout: no ack within 40 cycles for addr %0h", a);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, cpu_busy}, 0);
        chk({tag, "_cpu_ack"}, {31'b0, cpu_ack}, 0);
        chk({tag, "_cpu_rdata"}, {24'b0, cpu_rdata}, 0);
        chk({tag, "_vid_ack"}, {31'b0, vid_ack}, 0);
        chk({tag, "_vid_valid"}, {31'b0, vid_valid}, 0);
        chk({tag, "_vid_rdata"}, {24'b0, vid_rdata}, 0);
        chk({tag, "_mem_addr"}, {20'b0, mem_addr}, 0);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, 0);
        chk({tag, "_mem_wdata"}, {24'b0, mem_wdata}, 0);
        chk({tag, "_stall_cnt"}, {16'b0, stall_cnt}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int  lat, snap, vcnt;
    bit  done = 0;
    logic vack_k [1:12];

    initial begin
        for (int i = 0; i < 4096; i++) mdl[i] = pat(12'(i));

        // reset state, with vid_req high to see vid_ack held low
        vid_req = 1'b1; vid_addr = 12'h8AB;
        repeat (3) step();
        @(negedge clock);
        chk_all_zero("reset");
        step();
        reset = 1'b0; vid_req = 1'b0;

        // 1: uncontested write
        step();
        strobe(1'b1, 12'h123, 8'h5A);
        push_cpu(1'b1, 12'h123, 8'h5A);
        @(negedge clock); chk("t1_busy_T", {31'b0, cpu_busy}, 0);
        step(); cpu_req = 1'b0;
        @(negedge clock); chk("t1_busy_T1", {31'b0, cpu_busy}, 1); chk("t1_we_T1", {31'b0, mem_we}, 0);
        step();
        @(negedge clock);
        chk("t1_we_T2", {31'b0, mem_we}, 1);
        chk("t1_addr_T2", {20'b0, mem_addr}, 32'h123);
        chk("t1_wdata_T2", {24'b0, mem_wdata}, 32'h5A);
        chk("t1_ack_T2", {31'b0, cpu_ack}, 0);
        step();
        @(negedge clock); chk("t1_ack_T3", {31'b0, cpu_ack}, 1); chk("t1_busy_T3", {31'b0, cpu_busy}, 1);
        step();
        @(negedge clock); chk("t1_busy_T4", {31'b0, cpu_busy}, 0); chk("t1_ack_T4", {31'b0, cpu_ack}, 0);

        // 2: read back, video silent
        snap = vid_ack_cnt + vid_valid_cnt;
        cpu_op(1'b0, 12'h123, 8'h00, lat);
        chk("t2_latency", 32'(lat), 3);
        chk("t2_vid_silent", 32'(vid_ack_cnt + vid_valid_cnt - snap), 0);

        // 3: held video starves cpu for exactly LIM grants
        step();
        vid_req = 1'b1; vid_addr = 12'h900;
        strobe(1'b0, 12'h123, 8'h00);
        push_cpu(1'b0, 12'h123, 8'h00);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            cpu_req = 1'b0;
            vid_addr = 12'h800 | 12'($urandom_range(0, 2047));
            @(negedge clock);
            vack_k[k] = vid_ack;
            if (cpu_ack && lat < 0) lat = k;
        end
        vcnt = 0;
        for (int k = 1; k <= LIM; k++) vcnt += int'(vack_k[k]);
        chk("t3_vid_grants_before_cpu", 32'(vcnt), LIM);
        chk("t3_cpu_slot_no_vid_ack", {31'b0, vack_k[LIM+1]}, 0);
        chk("t3_vid_resumes", {31'b0, vack_k[LIM+2]}, 1);
        chk("t3_cpu_ack_latency", 32'(lat), LIM + 3);
        chk("t3_stall_cnt", {16'b0, stall_cnt}, EXP_STALL);

        // 4: simultaneous video and cpu, starve counter at 0
        step();
        vid_req = 1'b1; vid_addr = 12'hA00;
        strobe(1'b1, 12'h200, 8'h77);
        push_cpu(1'b1, 12'h200, 8'h77);
        @(negedge clock); chk("t4_vid_ack_same_cycle", {31'b0, vid_ack}, 1);
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            step(); vid_req = 1'b0; cpu_req = 1'b0;
            @(negedge clock);
            if (cpu_ack) lat = k;
        end
        chk("t4_cpu_ack_latency", 32'(lat), 3);
        chk("t4_stall_cnt", {16'b0, stall_cnt}, EXP_STALL);

        // 5: strobe while busy ignored; strobe in ack cycle accepted
        step(); strobe(1'b1, 12'h050, 8'h11); push_cpu(1'b1, 12'h050, 8'h11);
        step(); strobe(1'b1, 12'h051, 8'h22);
        step(); cpu_req = 1'b0;
        step(); strobe(1'b0, 12'h050, 8'h00); push_cpu(1'b0, 12'h050, 8'h00);
        @(negedge clock); chk("t5_ack_cycle", {31'b0, cpu_ack}, 1);
        step(); cpu_req = 1'b0;
        @(negedge clock); chk("t5_busy_after_reaccept", {31'b0, cpu_busy}, 1);
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            step();
            @(negedge clock);
            if (cpu_ack) lat = k;
        end
        chk("t5_second_ack", 32'(lat), 2);
        cpu_op(1'b0, 12'h051, 8'h00, lat);

        // 6: reset right after a cpu grant drops the access
        step(); strobe(1'b0, 12'h300, 8'h00);
        step(); cpu_req = 1'b0;
        step(); reset = 1'b1;
        @(negedge clock);
        chk_all_zero("t6");
        cpu_q.delete(); vid_q.delete();
        step(); step(); reset = 1'b0;
        snap = cpu_ack_cnt;
        repeat (5) step();
        @(negedge clock);
        chk("t6_no_ack_after_reset", 32'(cpu_ack_cnt - snap), 0);
        chk("t6_busy_after_reset", {31'b0, cpu_busy}, 0);

        // randomized mixed traffic
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    logic       we;
                    logic [11:0] a;
                    int l;
                    repeat ($urandom_range(0, 3)) step();
                    we = 1'($urandom_range(0, 1));
                    a  = we ? 12'($urandom_range(0, 2047)) : 12'($urandom_range(0, 4095));
                    cpu_op(we, a, 8'($urandom), l);
                    chk("rand_cpu_latency_bound", {31'b0, (l >= 3 && l <= LIM + 3)}, 1);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    step();
                    vid_req  = ($urandom_range(0, 3) != 0);
                    vid_addr = 12'h800 | 12'($urandom_range(0, 2047));
                end
                vid_req = 1'b0;
            end
        join

        repeat (6) step();
        @(negedge clock);
        chk("cpu_q_drained", 32'(cpu_q.size()), 0);
        chk("vid_q_drained", 32'(vid_q.size()), 0);
`ifndef VRAM_ARB_STATS_EN
        chk("stall_cnt_tied_off", {16'b0, stall_cnt}, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
